// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: FSM states,
// funct3 encodings and the M-extension funct7 value.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

endpackage

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage. Operates on operand
// magnitudes (shift-add multiply, restoring divide, one bit per BUSY cycle)
// and applies the result sign at the end. Fixed latency regardless of
// operands; divide-by-zero and signed overflow results are precomputed at
// accept and override the datapath on completion.
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            req_i,
  input  logic [9:0]      funct_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic [4:0]      rd_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_MAX = CW'(XLEN - 1);
  localparam logic [CW-1:0]   CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] X_ZERO  = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] X_ONES  = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] X_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  // Returns {result_negative, |op2| or op2, |op1| or op1} for the given op.
  function automatic logic [2*XLEN:0] prep(input logic [2:0] f3,
                                           input logic [XLEN-1:0] a,
                                           input logic [XLEN-1:0] b);
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    abs_a = a[XLEN-1] ? -a : a;
    abs_b = b[XLEN-1] ? -b : b;
    case (f3)
      F3_MUL, F3_MULH, F3_DIV: prep = {a[XLEN-1] ^ b[XLEN-1], abs_b, abs_a};
      F3_MULHSU:               prep = {a[XLEN-1], b, abs_a};
      F3_REM:                  prep = {a[XLEN-1], abs_b, abs_a};
      default:                 prep = {1'b0, b, a};
    endcase
  endfunction

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic [4:0]        rd_acc_q, rd_acc_d;
  logic [4:0]        rd_q, rd_d;
  logic              neg_q, neg_d;
  logic              spec_q, spec_d;
  logic [XLEN-1:0]   spec_val_q, spec_val_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic [2*XLEN:0]   prep_s;
  logic              accept_s;
  logic              div0_s;
  logic              ovf_s;
  logic [XLEN-1:0]   spec_val_s;
  logic [XLEN:0]     mul_sum_s;
  logic [2*XLEN-1:0] mul_next_s;
  logic [XLEN:0]     div_shift_s;
  logic [XLEN:0]     div_diff_s;
  logic [2*XLEN-1:0] div_next_s;
  logic [2*XLEN-1:0] step_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   div_val_s;
  logic [XLEN-1:0]   div_res_s;
  logic [XLEN-1:0]   final_s;
  logic              funct7_unused;

  assign funct7_unused = ^funct_i[9:3];
  assign prep_s        = prep(funct_i[2:0], op1_i, op2_i);
  assign accept_s      = (state_q == IDLE) && start_i && req_i;
  assign stall_o       = accept_s || (state_q == BUSY);
  assign done_o        = (state_q == DONE);
  assign result_o      = result_q;
  assign rd_o          = rd_q;

  // Special-case detection and override value, evaluated on the accept cycle.
  always_comb begin
    div0_s     = funct_i[2] && (op2_i == X_ZERO);
    ovf_s      = funct_i[2] && !funct_i[0] && (op1_i == X_MIN) && (op2_i == X_ONES);
    spec_val_s = X_ZERO;
    if (div0_s) begin
      spec_val_s = funct_i[1] ? op1_i : X_ONES;
    end else if (ovf_s) begin
      spec_val_s = funct_i[1] ? X_ZERO : op1_i;
    end else begin
      spec_val_s = X_ZERO;
    end
  end

  // One iteration of shift-add multiply or restoring divide, plus final result shaping.
  always_comb begin
    mul_sum_s   = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                  (acc_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
    mul_next_s  = {mul_sum_s, acc_q[XLEN-1:1]};
    div_shift_s = acc_q[2*XLEN-1:XLEN-1];
    div_diff_s  = div_shift_s - {1'b0, mcand_q};
    if (div_diff_s[XLEN]) begin
      div_next_s = {div_shift_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      div_next_s = {div_diff_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
    step_s    = f3_q[2] ? div_next_s : mul_next_s;
    prod_s    = neg_q ? -mul_next_s : mul_next_s;
    div_val_s = f3_q[1] ? div_next_s[2*XLEN-1:XLEN] : div_next_s[XLEN-1:0];
    div_res_s = neg_q ? -div_val_s : div_val_s;
    if (spec_q) begin
      final_s = spec_val_q;
    end else if (f3_q[2]) begin
      final_s = div_res_s;
    end else if (f3_q == F3_MUL) begin
      final_s = prod_s[XLEN-1:0];
    end else begin
      final_s = prod_s[2*XLEN-1:XLEN];
    end
  end

  // FSM next-state and register updates: accept in IDLE, iterate in BUSY, publish entering DONE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    f3_d       = f3_q;
    rd_acc_d   = rd_acc_q;
    rd_d       = rd_q;
    neg_d      = neg_q;
    spec_d     = spec_q;
    spec_val_d = spec_val_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    result_d   = result_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d    = BUSY;
          cnt_d      = CNT_MAX;
          f3_d       = funct_i[2:0];
          rd_acc_d   = rd_i;
          neg_d      = prep_s[2*XLEN];
          mcand_d    = prep_s[2*XLEN-1:XLEN];
          acc_d      = {X_ZERO, prep_s[XLEN-1:0]};
          spec_d     = div0_s || ovf_s;
          spec_val_d = spec_val_s;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        acc_d = step_s;
        if (cnt_q == {CW{1'b0}}) begin
          state_d  = DONE;
          result_d = final_s;
          rd_d     = rd_acc_q;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= {CW{1'b0}};
      f3_q       <= 3'b000;
      rd_acc_q   <= 5'd0;
      rd_q       <= 5'd0;
      neg_q      <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= X_ZERO;
      acc_q      <= {(2*XLEN){1'b0}};
      mcand_q    <= X_ZERO;
      result_q   <= X_ZERO;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      f3_q       <= f3_d;
      rd_acc_q   <= rd_acc_d;
      rd_q       <= rd_d;
      neg_q      <= neg_d;
      spec_q     <= spec_d;
      spec_val_q <= spec_val_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      result_q   <= result_d;
    end
  end

endmodule
